// File: rtl/sram2k8_ctrl.sv
// Bus master for a 2K x 8 asynchronous SRAM: turns a one-cycle host request into
// a SETUP / ACTIVE / HOLD pin sequence with a programmable strobe width.
module sram2k8_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic        req,
  input  logic        we,
  input  logic [10:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        busy,
  output logic [10:0] A0_A10,
  output logic        CS_n,
  output logic        OE_n,
  output logic        W_n,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        we_q, we_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cs_n_q, cs_n_d;
  logic        oe_n_q, oe_n_d;
  logic        w_n_q, w_n_d;
  logic        d_oe_q, d_oe_d;
  logic        ack_q, ack_d;

  // Sequencing and data capture
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wcnt_d  = WAIT_INIT;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (wcnt_q == 4'd0) begin
          state_d = HOLD;
          if (!we_q) begin
            rdata_d = D_in;
          end
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin levels are decoded from the next state so the strobes come straight
  // off flops and cannot glitch; OE_n and W_n are mutually exclusive by we_d.
  always_comb begin
    cs_n_d = (state_d == IDLE);
    oe_n_d = !((state_d == ACTIVE) && !we_d);
    w_n_d  = !((state_d == ACTIVE) && we_d);
    d_oe_d = we_d && (state_d != IDLE);
    ack_d  = (state_d == HOLD);
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 11'd0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      w_n_q   <= 1'b1;
      d_oe_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      w_n_q   <= w_n_d;
      d_oe_q  <= d_oe_d;
      ack_q   <= ack_d;
    end
  end

  assign rdata  = rdata_q;
  assign ack    = ack_q;
  assign busy   = (state_q != IDLE);
  assign A0_A10 = addr_q;
  assign D_out  = wdata_q;
  assign CS_n   = cs_n_q;
  assign OE_n   = oe_n_q;
  assign W_n    = w_n_q;
  assign D_oe   = d_oe_q;

endmodule

// File: tb/tb_sram2k8_ctrl.sv
// Self-checking bench: three controllers (WAIT_CYCLES 1, 0, 15) each driving
// a behavioural SRAM, checked against per-access timing rules and a memory model.
module tb_sram2k8_ctrl;

  function automatic int wc_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
  endfunction

  logic        sysclk = 1'b0;
  logic        sysreset;
  logic [2:0]  req, we_i, ack, busy, cs_n, oe_n, w_n, d_oe;
  logic [10:0] addr_i [3];
  logic [7:0]  wdata_i [3];
  logic [7:0]  rdata [3];
  logic [10:0] a_o [3];
  logic [7:0]  d_out [3];
  logic [7:0]  d_in [3];

  logic [7:0]  sram_mem [3][2048];
  logic [7:0]  ref_mem [3][2048];
  logic        mem_clr, pl_en;
  int          pl_k;
  logic [10:0] pl_a;
  logic [7:0]  pl_d;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    sram2k8_ctrl #(.WAIT_CYCLES(wc_of(gi))) dut (
      .sysclk  (sysclk),
      .sysreset(sysreset),
      .req     (req[gi]),
      .we      (we_i[gi]),
      .addr    (addr_i[gi]),
      .wdata   (wdata_i[gi]),
      .rdata   (rdata[gi]),
      .ack     (ack[gi]),
      .busy    (busy[gi]),
      .A0_A10  (a_o[gi]),
      .CS_n    (cs_n[gi]),
      .OE_n    (oe_n[gi]),
      .W_n     (w_n[gi]),
      .D_out   (d_out[gi]),
      .D_oe    (d_oe[gi]),
      .D_in    (d_in[gi])
    );
    assign d_in[gi] = (!cs_n[gi] && !oe_n[gi]) ? sram_mem[gi][a_o[gi]] : 8'hEE;
  end

  // Behavioural SRAM: stores whenever chip select, write strobe and drive overlap.
  always @(posedge sysclk) begin
    if (mem_clr) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 2048; i++)
          sram_mem[k][i] <= 8'h00;
    end else begin
      if (pl_en) sram_mem[pl_k][pl_a] <= pl_d;
      for (int k = 0; k < 3; k++)
        if (!cs_n[k] && !w_n[k] && d_oe[k]) sram_mem[k][a_o[k]] <= d_out[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int k, input logic [10:0] a, input logic [7:0] d);
    pl_k = k; pl_a = a; pl_d = d; pl_en = 1'b1;
    ref_mem[k][a] = d;
    @(negedge sysclk);
    pl_en = 1'b0;
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, "_cs"}, cs_n[k], 1'b1);
    chk({tag, "_oe"}, oe_n[k], 1'b1);
    chk({tag, "_w"}, w_n[k], 1'b1);
    chk({tag, "_doe"}, d_oe[k], 1'b0);
    chk({tag, "_ack"}, ack[k], 1'b0);
    chk({tag, "_busy"}, busy[k], 1'b0);
  endtask

  // One full access, called at a negedge; the next posedge is the accept edge.
  // Returns at the negedge of the first IDLE cycle after ack.
  task automatic access(input int k, input bit w, input logic [10:0] a,
                        input logic [7:0] d, input bit keep);
    int wc = wc_of(k);
    int cs_cnt = 0, st_cnt = 0, wrong_cnt = 0, doe_cnt = 0;
    int ack_at = 0, st_first = 0, bad = 0, dout_bad = 0, addr_bad = 0;
    logic [7:0] exp_rd = ref_mem[k][a];
    we_i[k] = w; addr_i[k] = a; wdata_i[k] = d; req[k] = 1'b1;
    for (int c = 1; c <= 40 && ack_at == 0; c++) begin
      @(negedge sysclk);
      if (c == 1) begin
        chk("accept_busy", busy[k], 1'b1);
        chk("accept_cs", cs_n[k], 1'b0);
        if (!keep) req[k] = 1'b0;
      end
      if (!cs_n[k]) begin
        cs_cnt++;
        if (a_o[k] !== a) addr_bad++;
      end
      if (w ? !w_n[k] : !oe_n[k]) begin
        st_cnt++;
        if (st_first == 0) st_first = c;
      end
      if (w ? !oe_n[k] : !w_n[k]) wrong_cnt++;
      if (!oe_n[k] && !w_n[k]) bad++;
      if (d_oe[k] && !oe_n[k]) bad++;
      if (d_oe[k]) begin
        doe_cnt++;
        if (d_out[k] !== d) dout_bad++;
      end
      if (ack[k] === 1'b1) begin
        ack_at = c;
        if (!w) chk("rdata_at_ack", rdata[k], exp_rd);
      end
    end
    chk("ack_cycle", ack_at, wc + 3);
    chk("cs_width", cs_cnt, wc + 3);
    chk("strobe_width", st_cnt, wc + 1);
    chk("strobe_start", st_first, 2);
    chk("other_strobe", wrong_cnt, 0);
    chk("doe_width", doe_cnt, w ? wc + 3 : 0);
    chk("pin_conflict", bad, 0);
    chk("dout_stable", dout_bad, 0);
    chk("addr_stable", addr_bad, 0);
    if (w) ref_mem[k][a] = d;
    @(negedge sysclk);
    chk_idle(k, "post_idle");
    $display("access inst=%0d wait=%0d we=%0d addr=%03h wdata=%02h rdata=%02h ack_cycle=%0d",
             k, wc, w, a, d, rdata[k], ack_at);
  endtask

  initial begin
    int n_bad;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 2048; i++)
        ref_mem[k][i] = 8'h00;
    sysreset = 1'b1; mem_clr = 1'b1; pl_en = 1'b0; pl_k = 0; pl_a = '0; pl_d = '0;
    req = 3'b111; we_i = 3'b111;
    for (int k = 0; k < 3; k++) begin
      addr_i[k] = 11'h7FF; wdata_i[k] = 8'hFF;
    end

    // Reset held with req asserted: nothing may start
    for (int c = 0; c < 3; c++) begin
      @(negedge sysclk);
      for (int k = 0; k < 3; k++) begin
        chk_idle(k, "reset");
        chk("reset_rdata", rdata[k], 8'h00);
        chk("reset_addr", a_o[k], 11'h000);
        chk("reset_dout", d_out[k], 8'h00);
      end
    end
    sysreset = 1'b0; mem_clr = 1'b0; req = 3'b000;
    @(negedge sysclk);
    chk("post_reset_busy", busy[0], 1'b0);

    // Directed write then read on WAIT_CYCLES=1
    access(0, 1'b1, 11'h7FF, 8'h5A, 1'b0);
    @(negedge sysclk);
    chk("sram_7ff", sram_mem[0][11'h7FF], 8'h5A);
    preload(0, 11'h123, 8'hA5);
    access(0, 1'b0, 11'h123, 8'h00, 1'b0);
    repeat (10) @(negedge sysclk);
    chk("rdata_hold", rdata[0], 8'hA5);

    // Back-to-back with req held across ack
    access(0, 1'b1, 11'h000, 8'h3C, 1'b1);
    access(0, 1'b0, 11'h000, 8'h00, 1'b0);
    chk("b2b_rdata", rdata[0], 8'h3C);

    // Reset during the second ACTIVE cycle of a write
    we_i[0] = 1'b1; addr_i[0] = 11'h555; wdata_i[0] = 8'h99; req[0] = 1'b1;
    @(negedge sysclk);
    req[0] = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    chk("midrst_in_active", w_n[0], 1'b0);
    sysreset = 1'b1;
    @(negedge sysclk);
    sysreset = 1'b0;
    chk_idle(0, "midrst");
    ref_mem[0][11'h555] = 8'h99;
    n_bad = 0;
    repeat (6) begin
      @(negedge sysclk);
      if (ack[0] !== 1'b0) n_bad++;
    end
    chk("midrst_no_ack", n_bad, 0);
    access(0, 1'b1, 11'h556, 8'h77, 1'b0);
    access(0, 1'b0, 11'h556, 8'h00, 1'b0);

    // Strobe-width extremes
    preload(1, 11'h400, 8'hC3);
    access(1, 1'b0, 11'h400, 8'h00, 1'b0);
    preload(2, 11'h400, 8'h4B);
    access(2, 1'b0, 11'h400, 8'h00, 1'b0);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      int k;
      bit w;
      logic [10:0] a;
      logic [7:0] d;
      k = int'($urandom_range(0, 2));
      w = 1'($urandom_range(0, 1));
      a = {6'h00, 5'($urandom_range(0, 31))};
      d = 8'($urandom);
      access(k, w, a, d, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge sysclk);
    end

    n_bad = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 2048; i++)
        if (sram_mem[k][i] !== ref_mem[k][i]) n_bad++;
    chk("final_mem", n_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
